// File: rtl/cdim_if_pkg.sv
// rtl/cdim_if_pkg.sv - shared types for the fetch-PC generator and its redirect latch
//
// Purpose : common constants and types used by pc_gen, pc_redirect_latch and
//           any debug trace that wants to report where the next PC came from.
// Contents: RESET_PC_DEFAULT, REDIRECT_ADDR_W, pc_src_e, redirect_t.
package cdim_if_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

  // Address field width of redirect_t; pc_gen supports ADDR_W up to this.
  localparam int REDIRECT_ADDR_W = 32;

  // Next-PC source, listed in priority order.
  typedef enum logic [2:0] {
    EXC      = 3'd0,
    PEND_EXC = 3'd1,
    BR       = 3'd2,
    PEND_BR  = 3'd3,
    HOLD     = 3'd4,
    SEQ      = 3'd5
  } pc_src_e;

  typedef struct packed {
    logic                       valid;
    logic                       is_exc;
    logic [REDIRECT_ADDR_W-1:0] addr;
  } redirect_t;

endpackage

// File: rtl/pc_redirect_latch.sv
// rtl/pc_redirect_latch.sv - pending-redirect register for redirects arriving while the PC is frozen
//
// Purpose : captures exception/branch redirects while pc_en=0 so none are lost,
//           and drops the pending entry on the first enabled cycle.
// Ports   : clk, rst (async, active-high)
//           pc_en                     - 1 = pipeline running, pending entry is consumed
//           is_except, except_addr    - exception redirect request and target
//           branch_taken, branch_addr - branch redirect request and target
//           pend                      - pending redirect {valid, is_exc, addr}
module pc_redirect_latch
  import cdim_if_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic              is_except,
  input  logic [ADDR_W-1:0] except_addr,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output redirect_t         pend
);

  logic              valid_q;
  logic              exc_q;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
      addr_q  <= '0;
    end else if (pc_en) begin
      // Whatever wins the next-PC mux this cycle, the pending entry is used up.
      valid_q <= 1'b0;
    end else if (is_except) begin
      // Exceptions always take the slot, even over an older exception.
      valid_q <= 1'b1;
      exc_q   <= 1'b1;
      addr_q  <= except_addr;
    end else if (branch_taken && !(valid_q && exc_q)) begin
      // A branch never displaces a pending exception, but replaces an older branch.
      valid_q <= 1'b1;
      exc_q   <= 1'b0;
      addr_q  <= branch_addr;
    end
  end

  always_comb begin
    pend                    = '0;
    pend.valid              = valid_q;
    pend.is_exc             = exc_q;
    pend.addr[ADDR_W-1:0]   = addr_q;
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - multi-width fetch-PC generator with prioritised and latched redirects
//
// Purpose : holds the fetch PC, advances it by the number of instructions
//           accepted (clamped to the end of the fetch block), applies
//           exception/branch redirects with fixed priority and pulses a flush
//           after every redirect-driven update.
// Ports   : clk, rst (async, active-high)
//           pc_en          - 0 freezes the PC; redirects are latched instead
//           accept_cnt     - instructions accepted into the FIFO this cycle
//           fifo_full      - hold the PC
//           is_except, except_addr, branch_taken, branch_addr - redirect requests
//           pc_curr        - current fetch PC (registered)
//           fetch_avail    - instructions left in the current fetch block
//           redirect_flush - one-cycle pulse after a redirect update
//           pend_valid     - a redirect is waiting in the pending latch
//           misaligned     - pc_curr[1:0] != 0
module pc_gen
  import cdim_if_pkg::*;
#(
  parameter int          FETCH_WIDTH = 2,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          ADDR_W      = 32,
  localparam int         CNT_W       = $clog2(FETCH_WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic [CNT_W-1:0]  accept_cnt,
  input  logic              fifo_full,
  input  logic              is_except,
  input  logic [ADDR_W-1:0] except_addr,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] pc_curr,
  output logic [CNT_W-1:0]  fetch_avail,
  output logic              redirect_flush,
  output logic              pend_valid,
  output logic              misaligned
);

  localparam int IDX_W  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 0;
  // Non-zero slice width so the unused FETCH_WIDTH=1 branch still elaborates cleanly.
  localparam int IDX_WS = (IDX_W > 0) ? IDX_W : 1;

  redirect_t         pend;
  pc_src_e           src;
  logic [CNT_W-1:0]  acc;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] pc_next;

  pc_redirect_latch #(
    .ADDR_W(ADDR_W)
  ) u_latch (
    .clk         (clk),
    .rst         (rst),
    .pc_en       (pc_en),
    .is_except   (is_except),
    .except_addr (except_addr),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .pend        (pend)
  );

  // Slot index inside the fetch block comes from pc_curr[2 +: IDX_W] only;
  // the low two bits never shrink the block, even on a misaligned target.
  generate
    if (FETCH_WIDTH == 1) begin : g_avail_single
      assign fetch_avail = CNT_W'(1);
    end else begin : g_avail_multi
      assign fetch_avail = CNT_W'(FETCH_WIDTH) - CNT_W'(pc_curr[2 +: IDX_WS]);
    end
  endgenerate

  // Clamp so an oversize count stops at the block boundary instead of wrapping.
  assign acc    = (accept_cnt < fetch_avail) ? accept_cnt : fetch_avail;
  assign pc_seq = pc_curr + (ADDR_W'(acc) << 2);

  always_comb begin
    src = SEQ;
    if (is_except)                    src = EXC;
    else if (pend.valid && pend.is_exc) src = PEND_EXC;
    else if (branch_taken)            src = BR;
    else if (pend.valid)              src = PEND_BR;
    else if (fifo_full)               src = HOLD;

    pc_next = pc_seq;
    case (src)
      EXC:      pc_next = except_addr;
      PEND_EXC: pc_next = pend.addr[ADDR_W-1:0];
      BR:       pc_next = branch_addr;
      PEND_BR:  pc_next = pend.addr[ADDR_W-1:0];
      HOLD:     pc_next = pc_curr;
      default:  pc_next = pc_seq;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_curr        <= ADDR_W'(RESET_PC);
      redirect_flush <= 1'b0;
    end else if (pc_en) begin
      pc_curr        <= pc_next;
      redirect_flush <= (src == EXC) || (src == PEND_EXC) || (src == BR) || (src == PEND_BR);
    end else begin
      redirect_flush <= 1'b0;
    end
  end

  assign pend_valid = pend.valid;
  assign misaligned = |pc_curr[1:0];

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard testbench for pc_gen (FETCH_WIDTH=2 and FETCH_WIDTH=4 instances)
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        rst4;
  logic        pc_en;
  logic [1:0]  accept_cnt;
  logic [2:0]  acc4;
  logic        fifo_full;
  logic        is_except;
  logic [31:0] except_addr;
  logic        branch_taken;
  logic [31:0] branch_addr;

  logic [31:0] pc_curr;
  logic [1:0]  fetch_avail;
  logic        redirect_flush;
  logic        pend_valid;
  logic        misaligned;

  logic [31:0] pc4;
  logic [2:0]  avail4;
  logic        flush4;
  logic        pend4;
  logic        mis4;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        pen;
    logic [1:0]  acc;
    logic        full;
    logic        exc;
    logic [31:0] eaddr;
    logic        br;
    logic [31:0] baddr;
    logic [31:0] pc;
    logic        flush;
    logic        pend;
    logic [1:0]  avail;
    logic        mis;
  } row_t;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        pend;
    logic [1:0]  avail;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  pc_gen #(.FETCH_WIDTH(2), .RESET_PC(32'hbfc00000), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .accept_cnt(accept_cnt), .fifo_full(fifo_full),
    .is_except(is_except), .except_addr(except_addr), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .pc_curr(pc_curr), .fetch_avail(fetch_avail),
    .redirect_flush(redirect_flush), .pend_valid(pend_valid), .misaligned(misaligned)
  );

  pc_gen #(.FETCH_WIDTH(4), .RESET_PC(32'hbfc00000), .ADDR_W(32)) dut4 (
    .clk(clk), .rst(rst4), .pc_en(pc_en), .accept_cnt(acc4), .fifo_full(fifo_full),
    .is_except(is_except), .except_addr(except_addr), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .pc_curr(pc4), .fetch_avail(avail4),
    .redirect_flush(flush4), .pend_valid(pend4), .misaligned(mis4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t mk(logic pen, logic [1:0] acc, logic full, logic exc, logic [31:0] eaddr,
                              logic br, logic [31:0] baddr, logic [31:0] pc, logic flush,
                              logic pend, logic [1:0] avail, logic mis);
    row_t r;
    r.pen = pen; r.acc = acc; r.full = full; r.exc = exc; r.eaddr = eaddr;
    r.br = br; r.baddr = baddr; r.pc = pc; r.flush = flush; r.pend = pend;
    r.avail = avail; r.mis = mis;
    return r;
  endfunction

  // Apply one row's inputs and queue what the FW=2 instance must show after the edge.
  task automatic drive(input row_t r);
    exp_t e;
    pc_en = r.pen; accept_cnt = r.acc; fifo_full = r.full;
    is_except = r.exc; except_addr = r.eaddr; branch_taken = r.br; branch_addr = r.baddr;
    e.pc = r.pc; e.flush = r.flush; e.pend = r.pend; e.avail = r.avail; e.mis = r.mis;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if (pc_curr !== 32'hbfc00000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc_curr, 32'hbfc00000); end
    checks++;
    if (pend_valid !== 1'b0 || redirect_flush !== 1'b0 || misaligned !== 1'b0) begin
      errors++; $display("FAIL reset_flags got=%b%b%b exp=000", pend_valid, redirect_flush, misaligned);
    end
    checks++;
    if (fetch_avail !== 2'd2) begin errors++; $display("FAIL reset_avail got=%0d exp=2", fetch_avail); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_rows(input string name, input row_t rows[$]);
    exp_t e;
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (pc_curr !== e.pc || redirect_flush !== e.flush || pend_valid !== e.pend ||
          fetch_avail !== e.avail || misaligned !== e.mis) begin
        errors++;
        $display("FAIL %s[%0d] got pc=%h fl=%b pv=%b av=%0d mis=%b exp pc=%h fl=%b pv=%b av=%0d mis=%b",
                 name, i, pc_curr, redirect_flush, pend_valid, fetch_avail, misaligned,
                 e.pc, e.flush, e.pend, e.avail, e.mis);
      end
    end
  endtask

  task automatic test_sequential;
    row_t rows[$];
    rows.push_back(mk(1, 2, 0, 0, 0, 0, 0, 32'hbfc00008, 0, 0, 2, 0));
    rows.push_back(mk(1, 2, 0, 0, 0, 0, 0, 32'hbfc00010, 0, 0, 2, 0));
    rows.push_back(mk(1, 2, 0, 0, 0, 0, 0, 32'hbfc00018, 0, 0, 2, 0));
    rows.push_back(mk(1, 3, 0, 0, 0, 0, 0, 32'hbfc00020, 0, 0, 2, 0));
    run_rows("seq", rows);
  endtask

  task automatic test_clamp;
    row_t rows[$];
    rows.push_back(mk(1, 0, 0, 0, 0, 1, 32'hbfc00004, 32'hbfc00004, 1, 0, 1, 0));
    rows.push_back(mk(1, 2, 0, 0, 0, 0, 0, 32'hbfc00008, 0, 0, 2, 0));
    rows.push_back(mk(1, 2, 1, 0, 0, 0, 0, 32'hbfc00008, 0, 0, 2, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'hbfc00008, 0, 0, 2, 0));
    rows.push_back(mk(0, 2, 0, 0, 0, 0, 0, 32'hbfc00008, 0, 0, 2, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'hbfc0000c, 0, 0, 1, 0));
    run_rows("clamp", rows);
  endtask

  task automatic test_pending;
    row_t rows[$];
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 32'h80001000, 32'hbfc0000c, 0, 1, 1, 0));
    rows.push_back(mk(0, 0, 0, 1, 32'hbfc00380, 0, 0, 32'hbfc0000c, 0, 1, 1, 0));
    rows.push_back(mk(0, 2, 0, 0, 0, 0, 0, 32'hbfc0000c, 0, 1, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 32'h80000000, 32'hbfc0000c, 0, 1, 1, 0));
    rows.push_back(mk(1, 2, 0, 0, 0, 0, 0, 32'hbfc00380, 1, 0, 2, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'hbfc00380, 0, 0, 2, 0));
    run_rows("pend_exc", rows);
  endtask

  task automatic test_overwrite;
    row_t rows[$];
    // newer branch replaces older pending branch
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 32'h80001000, 32'hbfc00380, 0, 1, 2, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 32'h80002000, 32'hbfc00380, 0, 1, 2, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h80002000, 1, 0, 2, 0));
    // pending exception beats a new branch
    rows.push_back(mk(0, 0, 0, 1, 32'hbfc00380, 0, 0, 32'h80002000, 0, 1, 2, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 1, 32'h80000000, 32'hbfc00380, 1, 0, 2, 0));
    // new exception beats a pending branch
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 32'h80001000, 32'hbfc00380, 0, 1, 2, 0));
    rows.push_back(mk(1, 0, 0, 1, 32'hbfc00180, 0, 0, 32'hbfc00180, 1, 0, 2, 0));
    // simultaneous exception+branch while frozen latches the exception
    rows.push_back(mk(0, 0, 0, 1, 32'hbfc00200, 1, 32'h80000000, 32'hbfc00180, 0, 1, 2, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'hbfc00200, 1, 0, 2, 0));
    // newer exception replaces an older pending exception
    rows.push_back(mk(0, 0, 0, 1, 32'hbfc00300, 0, 0, 32'hbfc00200, 0, 1, 2, 0));
    rows.push_back(mk(0, 0, 0, 1, 32'hbfc00400, 0, 0, 32'hbfc00200, 0, 1, 2, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'hbfc00400, 1, 0, 2, 0));
    // pending branch beats fifo_full
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 32'h80003000, 32'hbfc00400, 0, 1, 2, 0));
    rows.push_back(mk(1, 2, 1, 0, 0, 0, 0, 32'h80003000, 1, 0, 2, 0));
    run_rows("overwrite", rows);
  endtask

  task automatic test_priority;
    row_t rows[$];
    rows.push_back(mk(1, 2, 1, 1, 32'hbfc00380, 1, 32'h80000000, 32'hbfc00380, 1, 0, 2, 0));
    rows.push_back(mk(1, 2, 1, 0, 0, 1, 32'h80000010, 32'h80000010, 1, 0, 2, 0));
    rows.push_back(mk(1, 2, 0, 0, 0, 0, 0, 32'h80000018, 0, 0, 2, 0));
    run_rows("priority", rows);
  endtask

  task automatic test_wrap;
    row_t rows[$];
    rows.push_back(mk(1, 0, 0, 0, 0, 1, 32'hfffffffc, 32'hfffffffc, 1, 0, 1, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h00000000, 0, 0, 2, 0));
    rows.push_back(mk(1, 2, 0, 0, 0, 0, 0, 32'h00000008, 0, 0, 2, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 1, 32'h80000002, 32'h80000002, 1, 0, 2, 1));
    rows.push_back(mk(1, 2, 0, 0, 0, 0, 0, 32'h8000000a, 0, 0, 2, 1));
    run_rows("wrap", rows);
  endtask

  task automatic test_fw4;
    row_t r;
    exp_t e;
    checks++;
    if (pc4 !== 32'hbfc00000 || pend4 !== 1'b0) begin
      errors++; $display("FAIL fw4_reset got pc=%h pv=%b exp pc=bfc00000 pv=0", pc4, pend4);
    end
    rst4 = 1'b0;
    r = mk(1, 0, 0, 0, 0, 1, 32'h0000100c, 32'h0000100c, 1, 0, 2, 0);
    drive(r); acc4 = 3'd0;
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (pc4 !== e.pc || flush4 !== e.flush || avail4 !== 3'd1) begin
      errors++; $display("FAIL fw4_branch got pc=%h fl=%b av=%0d exp pc=%h fl=%b av=1", pc4, flush4, avail4, e.pc, e.flush);
    end
    r = mk(1, 0, 0, 0, 0, 0, 0, 32'h00001010, 0, 0, 2, 0);
    drive(r); acc4 = 3'd3;
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (pc4 !== e.pc || flush4 !== e.flush || avail4 !== 3'd4) begin
      errors++; $display("FAIL fw4_clamp got pc=%h fl=%b av=%0d exp pc=%h fl=%b av=4", pc4, flush4, avail4, e.pc, e.flush);
    end
    r = mk(1, 0, 0, 0, 0, 0, 0, 32'h00001020, 0, 0, 2, 0);
    drive(r); acc4 = 3'd4;
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (pc4 !== e.pc || mis4 !== 1'b0) begin
      errors++; $display("FAIL fw4_full_block got pc=%h mis=%b exp pc=%h mis=0", pc4, mis4, e.pc);
    end
    r = mk(0, 0, 0, 0, 0, 1, 32'h00002000, 32'h00001020, 0, 1, 2, 0);
    drive(r); acc4 = 3'd0;
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (pc4 !== e.pc || pend4 !== e.pend) begin
      errors++; $display("FAIL fw4_hold got pc=%h pv=%b exp pc=%h pv=%b", pc4, pend4, e.pc, e.pend);
    end
    #2;
    rst4 = 1'b1;
    #1;
    checks++;
    if (pc4 !== 32'hbfc00000 || pend4 !== 1'b0 || flush4 !== 1'b0) begin
      errors++; $display("FAIL fw4_async_reset got pc=%h pv=%b fl=%b exp pc=bfc00000 pv=0 fl=0", pc4, pend4, flush4);
    end
  endtask

  initial begin
    rst = 1'b0; rst4 = 1'b0;
    pc_en = 1'b0; accept_cnt = '0; acc4 = '0; fifo_full = 1'b0;
    is_except = 1'b0; except_addr = '0; branch_taken = 1'b0; branch_addr = '0;
    #1;
    rst4 = 1'b1;
    test_reset;
    test_sequential;
    test_clamp;
    test_pending;
    test_overwrite;
    test_priority;
    test_wrap;
    test_fw4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
